multicycle_control_unit: RTL

Parametrised multi-cycle successor to the single-cycle opcode decoder in the CPU datapath. It supports the same 6-bit instruction set, but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and asserts datapath strobes only in the cycle they apply. It adds a ready/valid handshake to instruction and data memory, a bus-timeout trap, and an illegal-opcode trap. It sits between the instruction/data memory ports and the register file/ALU/PC of the multi-cycle datapath.

---
 rtl/multicycle_control_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
//                bus-timeout trap and illegal-opcode trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               instr_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic               byteOperations,
    output logic               regDst,
    output logic               ALUsrc,
    output logic               regWrite,
    output logic               move,
    output logic               jump,
    output logic               link,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic               bus_error,
    output logic               busy
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] c_op_r    = 6'b000000;
    localparam logic [5:0] c_op_addi = 6'b000010;
    localparam logic [5:0] c_op_subi = 6'b000011;
    localparam logic [5:0] c_op_andi = 6'b000100;
    localparam logic [5:0] c_op_ori  = 6'b000101;
    localparam logic [5:0] c_op_slti = 6'b000111;
    localparam logic [5:0] c_op_lw   = 6'b001000;
    localparam logic [5:0] c_op_lb   = 6'b001001;
    localparam logic [5:0] c_op_sw   = 6'b010000;
    localparam logic [5:0] c_op_sb   = 6'b010001;
    localparam logic [5:0] c_op_beq  = 6'b100011;
    localparam logic [5:0] c_op_bne  = 6'b100111;
    localparam logic [5:0] c_op_move = 6'b100000;
    localparam logic [5:0] c_op_j    = 6'b111000;
    localparam logic [5:0] c_op_jal  = 6'b111001;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    function automatic logic f_legal(input logic [5:0] op);
        case (op)
            c_op_r, c_op_addi, c_op_subi, c_op_andi, c_op_ori, c_op_slti,
            c_op_lw, c_op_lb, c_op_sw, c_op_sb, c_op_beq, c_op_bne,
            c_op_move, c_op_j, c_op_jal: f_legal = 1'b1;
            default:                     f_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f_alu_op(input logic [5:0] op);
        case (op)
            c_op_r:                         f_alu_op = 3'b111;
            c_op_subi, c_op_beq, c_op_bne:  f_alu_op = 3'b110;
            c_op_slti:                      f_alu_op = 3'b100;
            c_op_ori:                       f_alu_op = 3'b001;
            c_op_andi:                      f_alu_op = 3'b000;
            c_op_addi, c_op_lw, c_op_lb, c_op_sw, c_op_sb,
            c_op_move:                      f_alu_op = 3'b101;
            default:                        f_alu_op = 3'b000;
        endcase
    endfunction

    state_t             r_state;
    logic [5:0]         r_op;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_instr_req, r_pc_write, r_mem_req, r_mem_we, r_byte;
    logic               r_reg_dst, r_alu_src, r_reg_write, r_move, r_jump, r_link;
    logic [ALUOP_W-1:0] r_alu_op;
    logic               r_illegal, r_bus_error, r_busy;

    state_t             w_state_nxt;
    logic [5:0]         w_op_nxt;
    logic               w_timeout;
    logic               w_alu_en;
    logic               w_jump_nxt;
    logic               w_branch_taken;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_timeout   = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_limit);
        case (r_state)
            S_RESET:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    w_op_nxt    = opcode;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!f_legal(r_op))      w_state_nxt = S_TRAP;
                else if (r_op == c_op_j) w_state_nxt = S_FETCH;
                else if (r_op == c_op_jal) w_state_nxt = S_WB;
                else                     w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (r_op == c_op_beq || r_op == c_op_bne)
                    w_state_nxt = S_FETCH;
                else if (r_op == c_op_lw || r_op == c_op_lb ||
                         r_op == c_op_sw || r_op == c_op_sb)
                    w_state_nxt = S_MEM;
                else
                    w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_ready)
                    w_state_nxt = (r_op == c_op_sw || r_op == c_op_sb) ? S_FETCH : S_WB;
                else if (w_timeout)
                    w_state_nxt = S_TRAP;
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_RESET;
        endcase
    end

    // Registered strobes are decoded from the upcoming state so they line up with it
    always_comb begin
        w_alu_en   = (w_state_nxt == S_EXEC || w_state_nxt == S_MEM || w_state_nxt == S_WB) &&
                     (w_op_nxt != c_op_jal);
        w_jump_nxt = (w_state_nxt == S_DECODE && w_op_nxt == c_op_j) ||
                     (w_state_nxt == S_WB     && w_op_nxt == c_op_jal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_op        <= 6'b000000;
            r_wait_cnt  <= '0;
            r_instr_req <= 1'b0;
            r_pc_write  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_byte      <= 1'b0;
            r_reg_dst   <= 1'b0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_move      <= 1'b0;
            r_jump      <= 1'b0;
            r_link      <= 1'b0;
            r_alu_op    <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            if (w_state_nxt != r_state)
                r_wait_cnt <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);

            r_instr_req <= (w_state_nxt == S_FETCH);
            r_mem_req   <= (w_state_nxt == S_MEM);
            r_mem_we    <= (w_state_nxt == S_MEM) && (w_op_nxt == c_op_sw || w_op_nxt == c_op_sb);
            r_byte      <= (w_state_nxt == S_MEM) && (w_op_nxt == c_op_lb || w_op_nxt == c_op_sb);
            r_reg_write <= (w_state_nxt == S_WB);
            r_reg_dst   <= (w_state_nxt == S_WB) && (w_op_nxt == c_op_r);
            r_move      <= (w_state_nxt == S_WB) && (w_op_nxt == c_op_move);
            r_link      <= (w_state_nxt == S_WB) && (w_op_nxt == c_op_jal);
            r_jump      <= w_jump_nxt;
            r_pc_write  <= w_jump_nxt;
            r_alu_op    <= w_alu_en ? ALUOP_W'(f_alu_op(w_op_nxt)) : '0;
            r_alu_src   <= w_alu_en && !(w_op_nxt == c_op_r || w_op_nxt == c_op_beq ||
                                         w_op_nxt == c_op_bne);
            r_busy      <= (w_state_nxt != S_RESET) && (w_state_nxt != S_TRAP);
            r_illegal   <= r_illegal || (r_state == S_DECODE && !f_legal(r_op));
            r_bus_error <= r_bus_error ||
                           (w_state_nxt == S_TRAP && (r_state == S_FETCH || r_state == S_MEM));
        end
    end

    // Handshake- and flag-qualified strobes act in the same cycle the input arrives
    assign w_branch_taken = (r_state == S_EXEC) &&
                            ((r_op == c_op_beq && zero) || (r_op == c_op_bne && !zero));

    assign instr_req      = r_instr_req;
    assign ir_write       = (r_state == S_FETCH) && instr_valid;
    assign pc_write       = r_pc_write || w_branch_taken;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign byteOperations = r_byte;
    assign regDst         = r_reg_dst;
    assign ALUsrc         = r_alu_src;
    assign regWrite       = r_reg_write;
    assign move           = r_move;
    assign jump           = r_jump;
    assign link           = r_link;
    assign ALUop          = r_alu_op;
    assign illegal        = r_illegal;
    assign bus_error      = r_bus_error;
    assign busy           = r_busy;

endmodule
`default_nettype wire
